// File: rtl/inst_sram.sv
// Instruction SRAM with a byte-enabled load port and a 1-cycle fetch port.
// After reset every word is swept to NOP_INST before either port is accepted.
module inst_sram #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DEPTH    = 4096,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(32'h00000013)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_valid_i,
    output logic                ld_ready_o,
    input  logic [ADDR_W-1:0]   ld_addr_i,
    input  logic [DATA_W-1:0]   ld_data_i,
    input  logic [DATA_W/8-1:0] ld_be_i,
    output logic                ld_err_o,
    input  logic                if_req_i,
    output logic                if_ready_o,
    input  logic [ADDR_W-1:0]   if_addr_i,
    input  logic                if_stall_i,
    output logic [DATA_W-1:0]   inst_o,
    output logic                inst_valid_o,
    output logic                inst_err_o
);
    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(NBYTES);
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = IDX_W + 1;
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  clr_cnt;
    logic              clr_we;
    logic [DATA_W-1:0] mem [DEPTH];

    logic             ld_acc, ld_ok, if_acc, if_ok;
    logic [IDX_W-1:0] ld_idx, if_idx;

    // Aligned and no address bits above the word index.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ((a & LOW_MASK) == '0) && ((a >> (OFF_W + IDX_W)) == '0);
    endfunction

    assign ld_ok  = addr_ok(ld_addr_i);
    assign if_ok  = addr_ok(if_addr_i);
    assign ld_idx = ld_addr_i[OFF_W +: IDX_W];
    assign if_idx = if_addr_i[OFF_W +: IDX_W];
    assign ld_acc = ld_valid_i && ld_ready_o && !rst;
    assign if_acc = if_req_i && if_ready_o && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (clr_we) clr_cnt <= clr_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt  = state;
        clr_we     = 1'b0;
        ld_ready_o = 1'b0;
        if_ready_o = 1'b0;
        case (state)
            CLEAR: begin
                clr_we = 1'b1;
                if (clr_cnt == CNT_W'(DEPTH - 1)) state_nxt = READY;
            end
            READY: begin
                ld_ready_o = 1'b1;
                if_ready_o = !ld_valid_i && !if_stall_i;
            end
        endcase
    end

    // Storage has no reset of its own; the CLEAR sweep initialises it.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt[IDX_W-1:0]] <= NOP_INST;
        end else if (ld_acc && ld_ok) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (ld_be_i[b]) mem[ld_idx][b*8 +: 8] <= ld_data_i[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_o       <= NOP_INST;
            inst_valid_o <= 1'b0;
            inst_err_o   <= 1'b0;
            ld_err_o     <= 1'b0;
        end else begin
            ld_err_o <= ld_acc && !ld_ok;
            if (!if_stall_i) begin
                inst_valid_o <= if_acc;
                inst_err_o   <= if_acc && !if_ok;
                if (if_acc) inst_o <= if_ok ? mem[if_idx] : NOP_INST;
            end
        end
    end
endmodule

// File: tb/tb_inst_sram.sv
// Directed bench for inst_sram: the driver queues expected fetch responses,
// an independent monitor pops them whenever a fresh inst_valid_o appears.
module tb_inst_sram;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned DP = 16;
    localparam logic [31:0] NOP = 32'h00000013;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ld_valid_i = 1'b0;
    logic          ld_ready_o;
    logic [AW-1:0] ld_addr_i = '0;
    logic [DW-1:0] ld_data_i = '0;
    logic [3:0]    ld_be_i = '0;
    logic          ld_err_o;
    logic          if_req_i = 1'b0;
    logic          if_ready_o;
    logic [AW-1:0] if_addr_i = '0;
    logic          if_stall_i = 1'b0;
    logic [DW-1:0] inst_o;
    logic          inst_valid_o;
    logic          inst_err_o;

    always #5 clk = ~clk;

    inst_sram #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .DEPTH   (DP),
        .NOP_INST(NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ld_valid_i  (ld_valid_i),
        .ld_ready_o  (ld_ready_o),
        .ld_addr_i   (ld_addr_i),
        .ld_data_i   (ld_data_i),
        .ld_be_i     (ld_be_i),
        .ld_err_o    (ld_err_o),
        .if_req_i    (if_req_i),
        .if_ready_o  (if_ready_o),
        .if_addr_i   (if_addr_i),
        .if_stall_i  (if_stall_i),
        .inst_o      (inst_o),
        .inst_valid_o(inst_valid_o),
        .inst_err_o  (inst_err_o)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } resp_t;

    resp_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    ld_err_cnt = 0;
    bit    mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // A response is fresh only if the edge that produced it was not stalled.
    always begin : monitor
        logic  st, rs;
        resp_t e;
        @(posedge clk);
        st = if_stall_i;
        rs = rst;
        @(negedge clk);
        if (mon_en && ld_err_o) ld_err_cnt++;
        if (mon_en && !st && !rs && inst_valid_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got inst %h with empty queue", inst_o);
            end else begin
                e = sb.pop_front();
                check("fetch_inst", inst_o, e.inst);
                check("fetch_err", {31'b0, inst_err_o}, {31'b0, e.err});
            end
        end
    end

    // Starts and ends on a negedge.
    task automatic reset_and_fetch0();
        int n;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if_req_i = 1'b1;
        if_addr_i = '0;
        #1;
        check("rst_inst_o", inst_o, NOP);
        check("rst_valid", {31'b0, inst_valid_o}, 32'd0);
        check("rst_err", {31'b0, inst_err_o}, 32'd0);
        check("rst_ld_err", {31'b0, ld_err_o}, 32'd0);
        check("rst_ld_ready", {31'b0, ld_ready_o}, 32'd0);
        check("rst_if_ready", {31'b0, if_ready_o}, 32'd0);
        n = 0;
        while (!if_ready_o && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("clear_cycles", n, 16);
        if (if_ready_o) sb.push_back('{inst: NOP, err: 1'b0});
        @(negedge clk);
        if_req_i = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp, input logic exp_err);
        int n;
        if_req_i = 1'b1;
        if_addr_i = a;
        #1;
        n = 0;
        while (!if_ready_o && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!if_ready_o) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: addr %h never accepted", a);
        end else begin
            sb.push_back('{inst: exp, err: exp_err});
        end
        @(negedge clk);
        if_req_i = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                           input logic exp_err);
        int n;
        ld_valid_i = 1'b1;
        ld_addr_i = a;
        ld_data_i = d;
        ld_be_i = be;
        #1;
        n = 0;
        while (!ld_ready_o && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!ld_ready_o) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: addr %h never accepted", a);
        end
        @(negedge clk);
        ld_valid_i = 1'b0;
        check("ld_err_pulse", {31'b0, ld_err_o}, {31'b0, exp_err});
    endtask

    initial begin
        @(negedge clk);
        reset_and_fetch0();
        mon_en = 1'b1;

        do_load(32'h8, 32'hDEADBEEF, 4'b1111, 1'b0);
        do_fetch(32'h8, 32'hDEADBEEF, 1'b0);
        do_load(32'h8, 32'h11223344, 4'b0001, 1'b0);
        do_fetch(32'h8, 32'hDEADBE44, 1'b0);
        do_load(32'h8, 32'hFFFFFFFF, 4'b0000, 1'b0);
        do_fetch(32'h8, 32'hDEADBE44, 1'b0);

        do_fetch(32'h6, NOP, 1'b1);
        do_fetch(32'h40, NOP, 1'b1);
        do_load(32'h40, 32'hA5A5A5A5, 4'b1111, 1'b1);
        do_fetch(32'h0, NOP, 1'b0);

        // Load and fetch presented together: load wins, fetch follows.
        ld_valid_i = 1'b1;
        ld_addr_i = 32'hC;
        ld_data_i = 32'hCAFEF00D;
        ld_be_i = 4'b1111;
        if_req_i = 1'b1;
        if_addr_i = 32'hC;
        #1;
        check("collide_if_ready", {31'b0, if_ready_o}, 32'd0);
        check("collide_ld_ready", {31'b0, ld_ready_o}, 32'd1);
        @(negedge clk);
        ld_valid_i = 1'b0;
        #1;
        check("after_load_if_ready", {31'b0, if_ready_o}, 32'd1);
        if (if_ready_o) sb.push_back('{inst: 32'hCAFEF00D, err: 1'b0});
        @(negedge clk);
        if_req_i = 1'b0;

        do_fetch(32'h8, 32'hDEADBE44, 1'b0);
        if_stall_i = 1'b1;
        if_req_i = 1'b1;
        if_addr_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_if_ready", {31'b0, if_ready_o}, 32'd0);
            @(negedge clk);
            check("stall_inst_o", inst_o, 32'hDEADBE44);
            check("stall_valid", {31'b0, inst_valid_o}, 32'd1);
        end
        if_stall_i = 1'b0;
        if_req_i = 1'b0;
        @(negedge clk);
        check("idle_valid", {31'b0, inst_valid_o}, 32'd0);
        check("idle_inst_hold", inst_o, 32'hDEADBE44);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        reset_and_fetch0();
        do_fetch(32'h8, NOP, 1'b0);
        do_fetch(32'hC, NOP, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        check("ld_err_count", ld_err_cnt, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end
endmodule

// File: doc/inst_sram.md
INST_SRAM -- requirements
Module: inst_sram

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction/word width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter DEPTH, default 4096, number of words; power of two.
REQ-004 SHALL have parameter NOP_INST, default 32'h00000013, fill and error value.
REQ-005 SHALL have clk  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ld_valid_i  in  1  load request.
REQ-008 SHALL have ld_ready_o  out  1  load accepted when high with ld_valid_i.
REQ-009 SHALL have ld_addr_i  in  ADDR_W  load byte address.
REQ-010 SHALL have ld_data_i  in  DATA_W  load data.
REQ-011 SHALL have ld_be_i  in  DATA_W/8  load byte enables.
REQ-012 SHALL have ld_err_o  out  1  one-cycle pulse: accepted load dropped.
REQ-013 SHALL have if_req_i  in  1  fetch request.
REQ-014 SHALL have if_ready_o  out  1  fetch accepted when high with if_req_i.
REQ-015 SHALL have if_addr_i  in  ADDR_W  fetch byte address (current pc).
REQ-016 SHALL have if_stall_i  in  1  consumer stall; holds output.
REQ-017 SHALL have inst_o  out  DATA_W  fetched instruction.
REQ-018 SHALL have inst_valid_o  out  1  inst_o valid.
REQ-019 SHALL have inst_err_o  out  1  fetch faulted (misaligned/out-of-range).

Function
REQ-020 SHALL run FSM states CLEAR and READY; CLEAR entered on rst, READY after final clear write.
REQ-021 SHALL, in CLEAR, write NOP_INST to word clr_cnt each cycle, clr_cnt 0..DEPTH-1, leaving CLEAR after exactly DEPTH cycles.
REQ-022 SHALL hold ld_ready_o=0 and if_ready_o=0 throughout CLEAR.
REQ-023 SHALL, in READY, drive ld_ready_o=1 continuously.
REQ-024 SHALL, in READY, drive if_ready_o = !ld_valid_i && !if_stall_i (load has priority over fetch).
REQ-025 SHALL compute word index = addr >> log2(DATA_W/8); aligned = low log2(DATA_W/8) address bits zero; in-range = index < DEPTH with no upper address bits set.
REQ-026 SHALL, on accepted load that is aligned and in-range, update only bytes with ld_be_i bit set; ld_be_i=0 writes nothing and is not an error.
REQ-027 SHALL, on accepted load misaligned or out-of-range, write nothing and pulse ld_err_o the following cycle.
REQ-028 SHALL return an accepted fetch with 1-cycle latency: inst_valid_o=1 and inst_o=mem[index] the cycle after acceptance.
REQ-029 SHALL, for a faulting fetch, return inst_o=NOP_INST, inst_err_o=1, inst_valid_o=1 with the same latency.
REQ-030 SHALL, while if_stall_i=1, hold inst_o, inst_valid_o, inst_err_o unchanged.
REQ-031 SHALL, in a cycle with no accepted fetch and no stall, drive inst_valid_o=0, inst_err_o=0, inst_o holding last value.
REQ-032 SHALL return data written by a load in cycle N to a fetch of the same word accepted in cycle N+1 or later.
REQ-033 SHALL size clr_cnt to log2(DEPTH)+1 bits with no wrap during CLEAR.

Reset
REQ-034 SHALL, on rst=1 at a clock edge, set state=CLEAR, clr_cnt=0, inst_o=NOP_INST, inst_valid_o=0, inst_err_o=0, ld_err_o=0, ld_ready_o=0, if_ready_o=0.
REQ-035 SHALL, on rst asserted mid-CLEAR or mid-fetch, discard progress, restart clear from word 0, drop any pending fetch response.
REQ-036 SHALL give memory contents no reset other than the CLEAR sweep.

Verification (DEPTH=16, DATA_W=32)
REQ-037 SHALL test: rst pulse, then fetches every cycle -> ready low 16 cycles; first fetch of 0x0 returns 0x00000013, valid=1, err=0.
REQ-038 SHALL test: load 0x8 data 0xDEADBEEF be=4'b1111, next-cycle fetch 0x8 -> inst_o=0xDEADBEEF one cycle later; load 0x8 data 0x11223344 be=4'b0001 -> fetch returns 0xDEADBE44.
REQ-039 SHALL test: fetch 0x6 and fetch 0x40 -> inst_o=0x00000013, inst_err_o=1, valid=1; load 0x40 -> ld_err_o pulse, no memory change.
REQ-040 SHALL test: ld_valid_i and if_req_i same cycle -> if_ready_o=0, load completes, fetch accepted next cycle.
REQ-041 SHALL test: fetch 0x8 then if_stall_i=1 for 3 cycles -> inst_o/valid held at 0xDEADBE44/1, no new acceptance.
REQ-042 SHALL test: rst at clear cycle 7 -> full 16-cycle clear repeats, outputs at reset values.
